// File: rtl/pipe_sel_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sel_mux_if
//  Description : Upstream select/valid/ready and downstream data/valid/ready
//                bundle for pipe_sel_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_sel_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        select;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport master (
        output in_bus, select, in_valid, flush, out_ready,
        input  in_ready, out, out_valid, sel_err
    );

    modport slave (
        input  in_bus, select, in_valid, flush, out_ready,
        output in_ready, out, out_valid, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/pipe_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sel_mux
//  Description : N:1 select mux feeding a 2-entry elastic skid buffer with
//                flush and out-of-range select flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_sel_mux #(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 5,
    parameter int SEL_W    = 3,
    parameter int OOR_MODE = 0
) (
    input  wire logic      clk,
    input  wire logic      reset,
    pipe_sel_mux_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_main_err;
    logic             r_skid_err;
    logic [WIDTH-1:0] w_pick;
    logic             w_pick_err;
    logic             w_accept;
    logic             w_pop;
    logic             w_main_ld_pick;
    logic             w_main_ld_skid;
    logic             w_skid_ld;

    // Handshake outputs come from registered state only
    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out       = r_main;
    assign bus.sel_err   = r_main_err & bus.out_valid;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_pop    = bus.out_valid & bus.out_ready;

    always_comb begin
        w_pick_err = (int'(bus.select) >= NUM_IN);
        w_pick     = (OOR_MODE != 0) ? '0 : bus.in_bus[WIDTH-1:0];
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(bus.select) == k) begin
                w_pick = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_pick = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_main_ld_pick = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_ld_pick = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_skid_ld   = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt    = ST_ONE;
                        w_main_ld_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // MAIN keeps its last value when the buffer drains; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main     <= '0;
            r_main_err <= 1'b0;
            r_skid     <= '0;
            r_skid_err <= 1'b0;
        end else begin
            if (w_main_ld_pick) begin
                r_main     <= w_pick;
                r_main_err <= w_pick_err;
            end else if (w_main_ld_skid) begin
                r_main     <= r_skid;
                r_main_err <= r_skid_err;
            end
            if (w_skid_ld) begin
                r_skid     <= w_pick;
                r_skid_err <= w_pick_err;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipe_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_sel_mux
//  Description : Directed and soak bench for pipe_sel_mux (OOR_MODE 0/1 and a
//                64-bit 2-input build) against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_sel_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_sel_mux_if #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) if0 ();
    pipe_sel_mux_if #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) if1 ();
    pipe_sel_mux_if #(.WIDTH(64), .NUM_IN(2), .SEL_W(1)) ifw ();

    pipe_sel_mux #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .OOR_MODE(0)) u_dut0 (
        .clk(clk), .reset(rst), .bus(if0.slave));
    pipe_sel_mux #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .OOR_MODE(1)) u_dut1 (
        .clk(clk), .reset(rst), .bus(if1.slave));
    pipe_sel_mux #(.WIDTH(64), .NUM_IN(2), .SEL_W(1), .OOR_MODE(0)) u_dutw (
        .clk(clk), .reset(rst), .bus(ifw.slave));

    // The companion builds mirror the main stimulus so all three share occupancy
    assign if1.in_bus    = if0.in_bus;
    assign if1.select    = if0.select;
    assign if1.in_valid  = if0.in_valid;
    assign if1.flush     = if0.flush;
    assign if1.out_ready = if0.out_ready;
    assign ifw.in_bus    = {~if0.in_bus[63:32], if0.in_bus[63:32],
                            ~if0.in_bus[31:0],  if0.in_bus[31:0]};
    assign ifw.select    = if0.select[0];
    assign ifw.in_valid  = if0.in_valid;
    assign ifw.flush     = if0.flush;
    assign ifw.out_ready = if0.out_ready;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [63:0] dw;
        logic        err;
    } ent_t;

    ent_t        q[$];
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    logic [63:0] lastw = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic ent_t mk_entry(input logic [2:0] sel, input logic [159:0] b,
                                      input logic [127:0] bw);
        ent_t        e;
        logic [159:0] sh;
        logic [127:0] shw;
        e.err = (sel >= 3'd5);
        sh    = b >> (32 * sel);
        shw   = bw >> (64 * sel[0]);
        e.d0  = e.err ? b[31:0] : sh[31:0];
        e.d1  = e.err ? 32'h0   : sh[31:0];
        e.dw  = shw[63:0];
        return e;
    endfunction

    always @(posedge clk) begin
        bit pop;
        bit acc;
        if (rst) begin
            q.delete();
            last0 = '0;
            last1 = '0;
            lastw = '0;
        end else begin
            pop = (q.size() > 0) && if0.out_ready;
            acc = if0.in_valid && (q.size() < 2);
            if (if0.flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(mk_entry(if0.select, if0.in_bus, ifw.in_bus));
            end
            if (q.size() > 0) begin
                last0 = q[0].d0;
                last1 = q[0].d1;
                lastw = q[0].dw;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit v;
            v = (q.size() > 0);
            chk("in_ready0",  if0.in_ready,  q.size() < 2);
            chk("out_valid0", if0.out_valid, v);
            chk("out0",       if0.out,       v ? q[0].d0 : last0);
            chk("sel_err0",   if0.sel_err,   v ? q[0].err : 1'b0);
            chk("in_ready1",  if1.in_ready,  q.size() < 2);
            chk("out_valid1", if1.out_valid, v);
            chk("out1",       if1.out,       v ? q[0].d1 : last1);
            chk("sel_err1",   if1.sel_err,   v ? q[0].err : 1'b0);
            chk("in_readyw",  ifw.in_ready,  q.size() < 2);
            chk("out_validw", ifw.out_valid, v);
            chk("outw",       ifw.out,       v ? q[0].dw : lastw);
            chk("sel_errw",   ifw.sel_err,   1'b0);
        end
    end

    task automatic default_bus();
        for (int k = 0; k < 5; k++) if0.in_bus[k*32 +: 32] = 32'h1000_0000 + k;
    endtask

    task automatic idle();
        if0.in_valid  = 1'b0;
        if0.flush     = 1'b0;
        if0.out_ready = 1'b0;
    endtask

    task automatic drain();
        idle();
        if0.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        if0.out_ready = 1'b0;
    endtask

    initial begin
        logic [2:0] seq [4];
        seq = '{3'd3, 3'd0, 3'd4, 3'd1};
        idle();
        default_bus();
        if0.select = '0;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_out_valid", if0.out_valid, 1'b0);
        chk("rst_sel_err",   if0.sel_err,   1'b0);
        chk("rst_in_ready",  if0.in_ready,  1'b1);
        chk("rst_out",       if0.out,       32'h0);
        rst = 1'b0;

        // Streaming selection, one entry per cycle
        if0.in_valid  = 1'b1;
        if0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if0.select = seq[i];
            @(negedge clk);
            chk("stream_out",   if0.out,       32'h1000_0000 + seq[i]);
            chk("stream_valid", if0.out_valid, 1'b1);
        end
        drain();

        // Backpressure: A, B fill the buffer, C waits
        if0.in_valid = 1'b1;
        if0.select   = 3'd0;
        @(negedge clk);
        if0.select   = 3'd1;
        @(negedge clk);
        if0.select   = 3'd2;
        @(negedge clk);
        chk("full_in_ready", if0.in_ready, 1'b0);
        chk("full_head_a",   if0.out,      32'h1000_0000);
        @(negedge clk);
        chk("full_hold_a",   if0.out,      32'h1000_0000);
        if0.out_ready = 1'b1;
        @(negedge clk);
        chk("order_b",       if0.out,      32'h1000_0001);
        chk("reopen_ready",  if0.in_ready, 1'b1);
        @(negedge clk);
        chk("order_c",       if0.out,      32'h1000_0002);
        if0.in_valid = 1'b0;
        @(negedge clk);
        chk("drained_valid", if0.out_valid, 1'b0);
        chk("drained_hold",  if0.out,       32'h1000_0002);

        // Out-of-range select in both modes
        if0.in_valid = 1'b1;
        if0.select   = 3'd7;
        @(negedge clk);
        chk("oor0_out", if0.out,     32'h1000_0000);
        chk("oor0_err", if0.sel_err, 1'b1);
        chk("oor1_out", if1.out,     32'h0);
        chk("oor1_err", if1.sel_err, 1'b1);
        if0.in_valid = 1'b0;
        @(negedge clk);
        chk("oor_empty_err", if0.sel_err, 1'b0);

        // Flush while full, with a same-cycle input that must be dropped
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.select    = 3'd4;
        @(negedge clk);
        if0.select    = 3'd2;
        @(negedge clk);
        if0.select    = 3'd1;
        if0.flush     = 1'b1;
        @(negedge clk);
        chk("flush_valid", if0.out_valid, 1'b0);
        chk("flush_ready", if0.in_ready,  1'b1);
        idle();
        if0.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_stays_empty", if0.out_valid, 1'b0);

        // Reset while full
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.select    = 3'd3;
        repeat (2) @(negedge clk);
        chk("pre_rst_full", if0.in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", if0.out_valid, 1'b0);
        chk("midrst_ready", if0.in_ready,  1'b1);
        chk("midrst_out",   if0.out,       32'h0);
        idle();

        // Soak
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 5; k++) if0.in_bus[k*32 +: 32] = $urandom;
            if0.select    = 3'($urandom_range(0, 7));
            if0.in_valid  = ($urandom_range(0, 2) != 0);
            if0.out_ready = ($urandom_range(0, 3) != 0);
            if0.flush     = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
